// File: rtl/fxp_pkg.sv
// Shared constants and state encoding for the Q2.14 datapath blocks.
package fxp_pkg;

    localparam int DATA_WIDTH_DEF = 16;
    localparam int FRAC_WIDTH_DEF = 14;

    localparam logic [DATA_WIDTH_DEF-1:0] Q_MAX = 16'h7FFF;
    localparam logic [DATA_WIDTH_DEF-1:0] Q_MIN = 16'h8000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/fxp_sat.sv
// fxp_sat: combinational signed narrowing with clip-to-rail; zero latency.
// Backpressure: none (pure function of din).
module fxp_sat
    import fxp_pkg::*;
#(
    parameter int IN_WIDTH  = 24,
    parameter int OUT_WIDTH = DATA_WIDTH_DEF
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic        [OUT_WIDTH-1:0] dout,
    output logic                        sat
);

    // Value fits only when every bit from the output sign bit upward agrees.
    logic [IN_WIDTH-OUT_WIDTH:0] top_bits;
    assign top_bits = din[IN_WIDTH-1:OUT_WIDTH-1];

    always_comb begin
        dout = din[OUT_WIDTH-1:0];
        sat  = 1'b0;
        if (!(&top_bits) && (|top_bits)) begin
            sat  = 1'b1;
            dout = din[IN_WIDTH-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                   : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/fxp_accumulator.sv
// fxp_accumulator: sums a frame of Q2.14 products, saturates to Q2.14; result 1 cycle after last accept.
// Backpressure: result held in DONE until out_ready; in_ready only in ACCUM. Option macro: FXP_ACC_SKIP_FLAGGED_EN.
module fxp_accumulator
    import fxp_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
    parameter int GUARD_BITS = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  abort,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_ovf,
    input  logic                  in_unf,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sat,
    output logic                  out_err,
    output logic                  busy
);

    localparam int ACC_WIDTH = DATA_WIDTH + GUARD_BITS;

    if (GUARD_BITS < LEN_WIDTH || FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_cfg
        $error("fxp_accumulator: GUARD_BITS must cover LEN_WIDTH and FRAC_WIDTH must be < DATA_WIDTH");
    end

    state_t                 state;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [LEN_WIDTH-1:0]   cnt;
    logic                   err;
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] addend;
    logic signed [ACC_WIDTH-1:0] acc_sum;
    logic                   flagged;
    logic                   accept;
    logic                   last;
    logic [DATA_WIDTH-1:0]  sat_data;
    logic                   sat_flag;

    assign flagged    = in_ovf | in_unf;
    assign accept     = (state == ACCUM) && in_valid && in_ready;
    assign last       = accept && ((cnt + LEN_WIDTH'(1)) == len_q);
    assign sample_ext = {{GUARD_BITS{in_data[DATA_WIDTH-1]}}, in_data};

`ifdef FXP_ACC_SKIP_FLAGGED_EN
    // Flagged samples still count toward the frame length but contribute nothing.
    assign addend = flagged ? '0 : sample_ext;
`else
    assign addend = sample_ext;
`endif

    assign acc_sum = acc + addend;

    fxp_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (DATA_WIDTH)
    ) u_sat (
        .din  (acc_sum),
        .dout (sat_data),
        .sat  (sat_flag)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            len_q     <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
        end else if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            err       <= 1'b0;
            acc       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        len_q <= length;
                        cnt   <= '0;
                        err   <= 1'b0;
                        acc   <= '0;
                        busy  <= 1'b1;
                        if (length == '0) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= '0;
                            out_sat   <= 1'b0;
                            out_err   <= 1'b0;
                        end else begin
                            state    <= ACCUM;
                            in_ready <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc_sum;
                        cnt <= cnt + LEN_WIDTH'(1);
                        err <= err | flagged;
                        if (last) begin
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= sat_data;
                            out_sat   <= sat_flag;
                            out_err   <= err | flagged;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fxp_accumulator.sv
// Directed-vector bench for fxp_accumulator with hand-computed Q2.14 results.
module tb_fxp_accumulator;

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  length;
    logic        abort;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_ovf;
    logic        in_unf;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_sat;
    logic        out_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;
    int acc_cnt = 0;

    fxp_accumulator dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .length    (length),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ovf    (in_ovf),
        .in_unf    (in_unf),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat),
        .out_err   (out_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Independent count of accepted samples.
    always @(posedge clk) if (in_valid && in_ready) acc_cnt++;

    typedef struct {
        int               len;
        logic [3:0][15:0] data;
        logic [3:0]       ovf;
        logic [3:0]       unf;
        logic [15:0]      exp_data;
        logic             exp_sat;
        logic             exp_err;
    } vec_t;

    vec_t vecs[9];

    function automatic vec_t mk(input int len, input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [15:0] d3,
                                input logic [3:0] ovf, input logic [3:0] unf,
                                input logic [15:0] ed, input logic es, input logic ee);
        vec_t v;
        v.len = len;
        v.data[0] = d0; v.data[1] = d1; v.data[2] = d2; v.data[3] = d3;
        v.ovf = ovf; v.unf = unf;
        v.exp_data = ed; v.exp_sat = es; v.exp_err = ee;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic start_frame(input int len);
        @(negedge clk);
        start = 1'b1; length = 8'(len);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send(input logic [15:0] d, input logic ovf, input logic unf);
        int k;
        k = 0;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        if (k >= 20) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_ovf = ovf; in_unf = unf;
        @(negedge clk);
        in_valid = 1'b0; in_ovf = 1'b0; in_unf = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
        chk("post_hs_busy", {31'd0, busy}, 32'd0);
    endtask

    int          lens[3] = '{7, 20, 1};
    int          sum;
    int          n;
    int          cyc;
    logic [15:0] dd;
    logic [15:0] exp_d;
    logic        exp_s;
    logic [15:0] held;

    initial begin
        reset = 1'b0; start = 1'b0; length = '0; abort = 1'b0;
        in_valid = 1'b0; in_data = '0; in_ovf = 1'b0; in_unf = 1'b0; out_ready = 1'b0;

        vecs[0] = mk(3, 16'h2000, 16'h2000, 16'h2000, 16'h0000, 4'b0000, 4'b0000, 16'h6000, 1'b0, 1'b0);
        vecs[1] = mk(4, 16'h4000, 16'h4000, 16'h4000, 16'h4000, 4'b0000, 4'b0000, 16'h7FFF, 1'b1, 1'b0);
        vecs[2] = mk(4, 16'hC000, 16'hC000, 16'hC000, 16'hC000, 4'b0000, 4'b0000, 16'h8000, 1'b1, 1'b0);
`ifdef FXP_ACC_SKIP_FLAGGED_EN
        vecs[3] = mk(2, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 16'h1000, 1'b0, 1'b1);
        vecs[4] = mk(2, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h0100, 1'b0, 1'b1);
`else
        vecs[3] = mk(2, 16'h1000, 16'h1000, 16'h0000, 16'h0000, 4'b0001, 4'b0000, 16'h2000, 1'b0, 1'b1);
        vecs[4] = mk(2, 16'h0100, 16'hFF00, 16'h0000, 16'h0000, 4'b0000, 4'b0010, 16'h0000, 1'b0, 1'b1);
`endif
        vecs[5] = mk(1, 16'h8000, 16'h0000, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h8000, 1'b0, 1'b0);
        vecs[6] = mk(2, 16'h7FFF, 16'h0001, 16'h0000, 16'h0000, 4'b0000, 4'b0000, 16'h7FFF, 1'b1, 1'b0);
        vecs[7] = mk(4, 16'h0800, 16'h0800, 16'h0800, 16'h0800, 4'b0000, 4'b0000, 16'h2000, 1'b0, 1'b0);
        vecs[8] = mk(3, 16'h7000, 16'h7000, 16'h9000, 16'h0000, 4'b0000, 4'b0000, 16'h7000, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        chk("reset_outputs", {26'd0, busy, in_ready, out_valid, out_sat, out_err, 1'b0},
            32'd0);
        chk("reset_out_data", {16'd0, out_data}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        for (int v = 0; v < 9; v++) begin
            start_frame(vecs[v].len);
            chk($sformatf("v%0d_busy", v), {31'd0, busy}, 32'd1);
            for (int i = 0; i < vecs[v].len; i++)
                send(vecs[v].data[i], vecs[v].ovf[i], vecs[v].unf[i]);
            chk($sformatf("v%0d_out_valid_latency", v), {31'd0, out_valid}, 32'd1);
            chk($sformatf("v%0d_in_ready_done", v), {31'd0, in_ready}, 32'd0);
            chk($sformatf("v%0d_out_data", v), {16'd0, out_data}, {16'd0, vecs[v].exp_data});
            chk($sformatf("v%0d_out_sat", v), {31'd0, out_sat}, {31'd0, vecs[v].exp_sat});
            chk($sformatf("v%0d_out_err", v), {31'd0, out_err}, {31'd0, vecs[v].exp_err});
            handshake();
        end

        // Zero-length frame: result 0, held under backpressure.
        start_frame(0);
        chk("len0_out_valid", {31'd0, out_valid}, 32'd1);
        chk("len0_out_data", {16'd0, out_data}, 32'd0);
        chk("len0_out_sat", {31'd0, out_sat}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("len0_hold%0d", i), {15'd0, out_valid, out_data}, 32'h0001_0000);
        end
        handshake();

        // Handshake and start together in DONE: start must be ignored.
        start_frame(1);
        send(16'h0123, 1'b0, 1'b0);
        chk("hs_start_data", {16'd0, out_data}, 32'h0000_0123);
        out_ready = 1'b1; start = 1'b1; length = 8'd2;
        @(negedge clk);
        out_ready = 1'b0; start = 1'b0;
        chk("hs_start_ignored", {30'd0, busy, in_ready}, 32'd0);

        // Reset mid-frame clears everything immediately.
        start_frame(4);
        send(16'h0800, 1'b0, 1'b0);
        send(16'h0800, 1'b0, 1'b0);
        reset = 1'b0;
        #1;
        chk("midreset_flags", {27'd0, busy, in_ready, out_valid, out_sat, out_err}, 32'd0);
        chk("midreset_out_data", {16'd0, out_data}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // New frame after reset, then abort in DONE discards the result.
        start_frame(4);
        for (int i = 0; i < 4; i++) send(16'h0800, 1'b0, 1'b0);
        chk("abort_pre_valid", {31'd0, out_valid}, 32'd1);
        chk("abort_pre_data", {16'd0, out_data}, 32'h0000_2000);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_done_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_done_busy", {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk("abort_stays_idle", {31'd0, out_valid}, 32'd0);

        // Abort mid-ACCUM, then the next frame starts from a cleared accumulator.
        start_frame(4);
        send(16'h1000, 1'b1, 1'b0);
        send(16'h1000, 1'b0, 1'b0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_accum_ready", {30'd0, busy, in_ready}, 32'd0);
        start_frame(1);
        send(16'h1234, 1'b0, 1'b0);
        chk("after_abort_data", {16'd0, out_data}, 32'h0000_1234);
        chk("after_abort_err", {31'd0, out_err}, 32'd0);
        handshake();

        // Random in_valid gaps with spurious start pulses during ACCUM.
        for (int f = 0; f < 3; f++) begin
            start_frame(lens[f]);
            acc_cnt = 0; sum = 0; n = 0; cyc = 0;
            while (n < lens[f] && cyc < 2000) begin
                start = ($urandom_range(0, 3) == 0);
                length = 8'd5;
                if (in_ready && $urandom_range(0, 2) != 0) begin
                    dd = 16'($urandom);
                    in_valid = 1'b1; in_data = dd;
                    sum += int'($signed(dd));
                    n++;
                end else begin
                    in_valid = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
            start = 1'b0; in_valid = 1'b0;
            if (sum > 32767) begin exp_d = 16'h7FFF; exp_s = 1'b1; end
            else if (sum < -32768) begin exp_d = 16'h8000; exp_s = 1'b1; end
            else begin exp_d = sum[15:0]; exp_s = 1'b0; end
            chk($sformatf("rnd%0d_out_valid", f), {31'd0, out_valid}, 32'd1);
            chk($sformatf("rnd%0d_out_data", f), {16'd0, out_data}, {16'd0, exp_d});
            chk($sformatf("rnd%0d_out_sat", f), {31'd0, out_sat}, {31'd0, exp_s});
            held = out_data;
            in_valid = 1'b1; in_data = 16'h1111;
            @(negedge clk);
            in_valid = 1'b0;
            chk($sformatf("rnd%0d_accepted", f), acc_cnt, lens[f]);
            chk($sformatf("rnd%0d_held", f), {16'd0, out_data}, {16'd0, held});
            handshake();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
